// File: rtl/elk_pkg.sv
// Shared Electron ROM definitions: ROM geometry, loader state encoding and a
// saturating counter helper used by the ROM loader.
package elk_pkg;

   localparam int unsigned ELK_ROM_AW   = 17;
   localparam int unsigned ELK_ROM_SIZE = 114688;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } elk_state_t;

   function automatic logic [ELK_ROM_AW-1:0] sat_inc(
      input logic [ELK_ROM_AW-1:0] value,
      input logic [ELK_ROM_AW-1:0] limit
   );
      return (value >= limit) ? value : value + ELK_ROM_AW'(1);
   endfunction

endpackage

// File: rtl/elk_rom_loader.sv
// Electron ROM loader: turns ioctl byte downloads into ROM writes and holds the
// core in reset until the image settles. ELK_ROM_LOADER_CHECKSUM_EN adds rom_checksum.
module elk_rom_loader
   import elk_pkg::*;
#(
   parameter logic [7:0]  ROM_INDEX   = 8'd0,
   parameter int unsigned ROM_WORDS   = ELK_ROM_SIZE,
   parameter int unsigned HOLD_CYCLES = 256
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  ioctl_download,
   input  logic [7:0]            ioctl_index,
   input  logic                  ioctl_wr,
   input  logic [24:0]           ioctl_addr,
   input  logic [7:0]            ioctl_dout,
   output logic [ELK_ROM_AW-1:0] rom_addr,
   output logic [7:0]            rom_data,
   output logic                  rom_wren,
   output logic                  core_reset,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ELK_ROM_AW-1:0] byte_count
`ifdef ELK_ROM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]            rom_checksum
`endif
);

   localparam int unsigned           CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]      HOLD_INIT  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [24:0]           ADDR_LIMIT = 25'(ROM_WORDS);
   localparam logic [ELK_ROM_AW-1:0] COUNT_MAX  = ELK_ROM_AW'(ROM_WORDS);

   elk_state_t       state;
   elk_state_t       state_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic             start_req;
   logic             load_entry;
   logic             wr_ok;
   logic             wr_bad;

   assign start_req  = ioctl_download && (ioctl_index == ROM_INDEX);
   assign load_entry = (state != LOAD) && (state_nxt == LOAD);
   assign wr_ok      = (state == LOAD) && ioctl_wr && (ioctl_addr <  ADDR_LIMIT);
   assign wr_bad     = (state == LOAD) && ioctl_wr && (ioctl_addr >= ADDR_LIMIT);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start_req) state_nxt = LOAD;
         LOAD: if (!ioctl_download) state_nxt = HOLD;
         HOLD: begin
            if (start_req) begin
               state_nxt = LOAD;
            end else if (hold_cnt == '0) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // load_done is suppressed when a matching download restarts on the final hold cycle
   always_comb begin
      core_reset = 1'b0;
      load_done  = 1'b0;
      unique case (state)
         IDLE: begin
         end
         LOAD: core_reset = 1'b1;
         HOLD: begin
            core_reset = 1'b1;
            load_done  = (hold_cnt == '0) && !start_req;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if ((state == LOAD) && !ioctl_download) begin
         hold_cnt <= HOLD_INIT;
      end else if ((state == HOLD) && (hold_cnt != '0)) begin
         hold_cnt <= hold_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rom_addr   <= '0;
         rom_data   <= '0;
         rom_wren   <= 1'b0;
         load_error <= 1'b0;
         byte_count <= '0;
      end else begin
         rom_wren <= wr_ok;
         if (wr_ok) begin
            rom_addr   <= ioctl_addr[ELK_ROM_AW-1:0];
            rom_data   <= ioctl_dout;
            byte_count <= sat_inc(byte_count, COUNT_MAX);
         end
         if (wr_bad) begin
            load_error <= 1'b1;
         end
         if (load_entry) begin
            byte_count <= '0;
            load_error <= 1'b0;
         end
      end
   end

`ifdef ELK_ROM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rom_checksum <= '0;
      end else if (load_entry) begin
         rom_checksum <= '0;
      end else if (wr_ok) begin
         rom_checksum <= rom_checksum + ioctl_dout;
      end
   end
`endif

endmodule

// File: tb/tb_elk_rom_loader.sv
// Self-checking bench for elk_rom_loader: directed scenarios plus randomized
// ioctl traffic compared every cycle against a behavioural loader model.
module tb_elk_rom_loader;

   localparam int unsigned HOLD  = 4;
   localparam int unsigned WORDS = 114688;

   logic        clk_sys        = 1'b0;
   logic        reset          = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index    = 8'd0;
   logic        ioctl_wr       = 1'b0;
   logic [24:0] ioctl_addr     = '0;
   logic [7:0]  ioctl_dout     = 8'd0;
   logic [16:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_wren;
   logic        core_reset;
   logic        load_done;
   logic        load_error;
   logic [16:0] byte_count;
`ifdef ELK_ROM_LOADER_CHECKSUM_EN
   logic [7:0]  rom_checksum;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned n_done   = 0;
   bit          checking = 1'b0;

   // behavioural model state
   bit          m_loading   = 1'b0;
   int          m_hold_left = 0;
   int          m_count     = 0;
   bit          m_err       = 1'b0;
   bit          m_wren      = 1'b0;
   int          m_addr      = 0;
   int          m_data      = 0;
   int          m_sum       = 0;

   always #5 clk_sys = ~clk_sys;

   elk_rom_loader #(
      .ROM_INDEX   (8'd0),
      .ROM_WORDS   (WORDS),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .rom_wren       (rom_wren),
      .core_reset     (core_reset),
      .load_done      (load_done),
      .load_error     (load_error),
      .byte_count     (byte_count)
`ifdef ELK_ROM_LOADER_CHECKSUM_EN
      ,
      .rom_checksum   (rom_checksum)
`endif
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: a load collects bytes, then core reset is held for HOLD cycles after download drops.
   always @(posedge clk_sys) begin
      if (reset) begin
         m_loading = 1'b0; m_hold_left = 0; m_count = 0; m_err = 1'b0;
         m_wren = 1'b0; m_addr = 0; m_data = 0; m_sum = 0;
      end else begin
         m_wren = 1'b0;
         if (m_loading) begin
            if (ioctl_wr) begin
               if (ioctl_addr < WORDS) begin
                  m_wren = 1'b1;
                  m_addr = int'(ioctl_addr % 25'd131072);
                  m_data = int'(ioctl_dout);
                  if (m_count < WORDS) m_count++;
                  m_sum = (m_sum + int'(ioctl_dout)) % 256;
               end else begin
                  m_err = 1'b1;
               end
            end
            if (!ioctl_download) begin
               m_loading   = 1'b0;
               m_hold_left = HOLD;
            end
         end else if (ioctl_download && ioctl_index == 8'd0) begin
            m_loading = 1'b1; m_hold_left = 0; m_count = 0; m_err = 1'b0; m_sum = 0;
         end else if (m_hold_left > 0) begin
            m_hold_left--;
         end
      end
   end

   always @(negedge clk_sys) begin
      if (load_done === 1'b1) n_done++;
      if (checking) begin
         chk("rom_wren",   rom_wren,   m_wren);
         chk("rom_addr",   rom_addr,   m_addr);
         chk("rom_data",   rom_data,   m_data);
         chk("byte_count", byte_count, m_count);
         chk("load_error", load_error, m_err);
         chk("core_reset", core_reset, m_loading || (m_hold_left > 0));
         chk("load_done",  load_done,
             (m_hold_left == 1) && !(ioctl_download && ioctl_index == 8'd0));
`ifdef ELK_ROM_LOADER_CHECKSUM_EN
         chk("rom_checksum", rom_checksum, m_sum);
`endif
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic begin_dl(input logic [7:0] idx);
      ioctl_download = 1'b1;
      ioctl_index    = idx;
      tick();
   endtask

   task automatic end_dl();
      ioctl_download = 1'b0;
      tick();
   endtask

   task automatic wr_byte(input int unsigned a, input logic [7:0] d);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = d;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic wait_idle();
      int i = 0;
      while (core_reset !== 1'b0 && i < 50) begin
         tick();
         i++;
      end
      chk("wait_idle_bound", (i < 50), 1);
   endtask

   initial begin
      logic [7:0] d35 [4];
      int unsigned done0;
      int unsigned r;
      d35 = '{8'hA5, 8'h5A, 8'hFF, 8'h00};

      repeat (2) @(posedge clk_sys);
      #1;
      checking = 1'b1;
      chk("rst_wren", rom_wren, 0);
      chk("rst_core_reset", core_reset, 0);
      chk("rst_byte_count", byte_count, 0);
      chk("rst_rom_addr", rom_addr, 0);
      reset = 1'b0;
      tick();

      // four-byte load with the reference pattern
      begin_dl(8'd0);
      chk("entry_core_reset", core_reset, 1);
      for (int i = 0; i < 4; i++) begin
         wr_byte(i, d35[i]);
         chk("w_wren", rom_wren, 1);
         chk("w_addr", rom_addr, i);
         chk("w_data", rom_data, d35[i]);
         tick();
         chk("w_wren_low", rom_wren, 0);
         chk("w_data_hold", rom_data, d35[i]);
      end
      chk("load4_count", byte_count, 4);
      chk("model4_count", m_count, 4);
`ifdef ELK_ROM_LOADER_CHECKSUM_EN
      chk("load4_checksum", rom_checksum, 8'hFE);
`endif
      end_dl();
      for (int k = 1; k <= 4; k++) begin
         chk("hold_core_reset", core_reset, 1);
         chk("hold_load_done", load_done, (k == 4));
         tick();
      end
      chk("post_hold_core_reset", core_reset, 0);
      chk("post_hold_load_done", load_done, 0);

      // address boundary and sticky error
      begin_dl(8'd0);
      wr_byte(WORDS - 1, 8'h77);
      chk("last_addr_wren", rom_wren, 1);
      chk("last_addr", rom_addr, 17'(WORDS - 1));
      wr_byte(WORDS, 8'h11);
      chk("oor_wren", rom_wren, 0);
      chk("oor_error", load_error, 1);
      tick();
      chk("oor_error_sticky", load_error, 1);
      end_dl();
      wait_idle();
      chk("error_kept_idle", load_error, 1);
      begin_dl(8'd0);
      chk("entry_clears_error", load_error, 0);
      chk("entry_clears_count", byte_count, 0);
      end_dl();
      wait_idle();

      // foreign index is ignored
      begin_dl(8'd1);
      chk("idx1_core_reset", core_reset, 0);
      for (int i = 0; i < 10; i++) begin
         wr_byte(i, 8'(i + 1));
         chk("idx1_wren", rom_wren, 0);
         chk("idx1_core_reset_w", core_reset, 0);
      end
      end_dl();

      // reset colliding with a write
      begin_dl(8'd0);
      tick();
      ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h3C; reset = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      chk("rst_wr_wren", rom_wren, 0);
      chk("rst_wr_core_reset", core_reset, 0);
      chk("rst_wr_load_done", load_done, 0);
      chk("rst_wr_count", byte_count, 0);
      reset = 1'b0; ioctl_download = 1'b0;
      tick();

      // restart during hold
      begin_dl(8'd0);
      wr_byte(0, 8'h42);
      end_dl();
      tick();
      done0 = n_done;
      ioctl_download = 1'b1; ioctl_index = 8'd0;
      tick();
      chk("restart_count", byte_count, 0);
      chk("restart_core_reset", core_reset, 1);
      wr_byte(1, 8'h24);
      chk("restart_count1", byte_count, 1);
      chk("restart_no_done_yet", n_done - done0, 0);
      end_dl();
      wait_idle();
      chk("restart_single_done", n_done - done0, 1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         reset = (r < 2);
         if (r >= 2 && r < 8) ioctl_download = ~ioctl_download;
         ioctl_index = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
         ioctl_wr    = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0: ioctl_addr = 25'($urandom_range(0, WORDS - 1));
            1: ioctl_addr = 25'(WORDS - 1);
            2: ioctl_addr = 25'(WORDS + $urandom_range(0, 3));
            default: ioctl_addr = 25'($urandom);
         endcase
         ioctl_dout = 8'($urandom);
         tick();
      end
      reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      tick();
      wait_idle();
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elk_rom_loader.md
ELK_ROM_LOADER -- requirements
Module: elk_rom_loader

Interface
REQ-001 SHALL have parameter ROM_INDEX, default 8'd0: ioctl_index value selecting a ROM download.
REQ-002 SHALL have parameter ROM_WORDS, default 114688: number of ROM bytes that can be written.
REQ-003 SHALL have parameter HOLD_CYCLES, default 256: number of cycles core reset is held after a download ends.
REQ-004 SHALL have port clk_sys, input, 1: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ioctl_download, input, 1: download in progress.
REQ-007 SHALL have port ioctl_index, input, 8: download target index.
REQ-008 SHALL have port ioctl_wr, input, 1: one-cycle byte strobe.
REQ-009 SHALL have port ioctl_addr, input, 25: byte address.
REQ-010 SHALL have port ioctl_dout, input, 8: byte data.
REQ-011 SHALL have port rom_addr, output, 17: ROM write address.
REQ-012 SHALL have port rom_data, output, 8: ROM write data.
REQ-013 SHALL have port rom_wren, output, 1: ROM write enable.
REQ-014 SHALL have port core_reset, output, 1: holds the Electron core in reset.
REQ-015 SHALL have port load_done, output, 1: one-cycle pulse at the end of the hold period.
REQ-016 SHALL have port load_error, output, 1: sticky flag set when an address is out of range.
REQ-017 SHALL have port byte_count, output, 17: number of bytes written in the current load.

Function
REQ-018 SHALL implement the states IDLE, LOAD and HOLD.
REQ-019 In IDLE or HOLD, SHALL enter LOAD on the cycle after ioctl_download=1 with ioctl_index==ROM_INDEX.
  - On that entry, byte_count and load_error SHALL clear.
REQ-020 SHALL ignore downloads whose index is not ROM_INDEX; in that case the state and all outputs stay unchanged.
REQ-021 In LOAD, an ioctl_wr with ioctl_addr<ROM_WORDS SHALL produce, one cycle later:
  - rom_wren=1 for exactly one cycle;
  - rom_addr=ioctl_addr[16:0] and rom_data=ioctl_dout;
  - byte_count incremented by 1, saturating at ROM_WORDS.
REQ-022 In LOAD, an ioctl_wr with ioctl_addr>=ROM_WORDS SHALL NOT write and SHALL set load_error; load_error then stays set until the next LOAD entry or reset.
REQ-023 rom_addr and rom_data SHALL hold their last values while rom_wren=0.
REQ-024 In LOAD, ioctl_download=0 SHALL move the state to HOLD and load a counter with HOLD_CYCLES-1.
  - An ioctl_wr on that same cycle SHALL still be written.
REQ-025 In HOLD, the counter SHALL decrement each cycle; when it reaches 0 the state SHALL go to IDLE.
  - On that same cycle, load_done SHALL pulse high for one cycle.
REQ-026 core_reset SHALL be 1 in LOAD and HOLD and 0 in IDLE; it SHALL deassert on the cycle after the load_done pulse.
REQ-027 A matching download that restarts during HOLD SHALL discard the remaining count and SHALL produce no load_done.
REQ-028 ioctl_wr outside LOAD SHALL be ignored.

Reset
REQ-029 While reset=1, the state SHALL be IDLE and all outputs SHALL be 0 (rom_addr=0, rom_data=0, rom_wren=0, core_reset=0, load_done=0, load_error=0, byte_count=0).
REQ-030 Reset during LOAD or HOLD SHALL abort the operation at once.
  - No write SHALL occur on the cycle after reset is asserted, even if ioctl_wr was high.
  - The pending load_done SHALL be dropped.

Configuration
REQ-031 With ELK_ROM_LOADER_CHECKSUM_EN defined, SHALL provide an 8-bit output rom_checksum: the modulo-256 sum of all bytes written in the current load.
  - It SHALL clear on LOAD entry and update in the rom_wren cycle.
REQ-032 Without ELK_ROM_LOADER_CHECKSUM_EN, the port rom_checksum and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 SHALL take the state enum (IDLE/LOAD/HOLD), the ROM address width (17) and the ROM size (114688) from shared package elk_pkg.
REQ-034 SHALL be one flat module; the hold counter is inline and no sub-module is required.

Verification
REQ-035 Load with index 0, writing 4 bytes to addresses 0..3 with data A5,5A,FF,00 ->
  - four single-cycle rom_wren pulses with matching addr/data, each 1 cycle after ioctl_wr;
  - byte_count=4; rom_checksum=0xFE (with the macro defined).
REQ-036 Download falls with HOLD_CYCLES=4 -> core_reset stays 1 for 4 cycles, then load_done pulses once, then core_reset=0 on the next cycle.
REQ-037 Write to address 114688 with data 0x11 -> no rom_wren, load_error=1; the next LOAD entry clears load_error.
REQ-038 Download with index 1 carrying 10 writes -> no rom_wren, and core_reset stays 0.
REQ-039 reset asserted on the same cycle as ioctl_wr in LOAD -> next cycle rom_wren=0, core_reset=0, state IDLE, no load_done.
REQ-040 New index-0 download starting at HOLD cycle 2 -> LOAD re-entered, byte_count=0, no load_done until the second hold period expires.
